dm_arbiter: RTL

Two-port arbiter and sequencer in front of the word-indexed data memory of the RV32I core. It shares the memory's single port between the CPU load/store unit (port C) and a debug/DMA loader (port D) using round-robin arbitration. It registers read data with one-cycle latency and can optionally sweep the memory to zero with a clear engine. Memory side matches the data memory: combinational read, write on posedge clk when m_we=1.

---
 rtl/dm_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/dm_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The optional clear engine in dm_arbiter is enabled by DM_ARB_CLEAR_EN.
package dm_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic ID_C = 1'b0;
    localparam logic ID_D = 1'b1;

    localparam int DEFAULT_DEPTH = 100;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; a tie goes to the requester not granted last.
// The last-grant pointer only moves on a grant while en=1.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_q == ID_D) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        if (gnt[ID_C]) begin
            last_d = ID_C;
        end else if (gnt[ID_D]) begin
            last_d = ID_D;
        end
    end

    // Reset pointer at D so that C wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= ID_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single data-memory port between CPU (C) and DMA (D) with round-robin grants.
// Define DM_ARB_CLEAR_EN to compile in the zero-fill sweep (CLEAR state, counter, clr_start).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wd,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wd,
    output logic          c_gnt,
    output logic          d_gnt,
    output logic          c_rvalid,
    output logic          d_rvalid,
    output logic [31:0]   c_rdata,
    output logic [31:0]   d_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_ad,
    output logic [31:0]   m_wd,
    input  logic [31:0]   m_rd,
    input  logic          clr_start,
    output logic          clr_busy
);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          arb_en;
    logic [1:0]    arb_req;
    logic [1:0]    arb_gnt;
    logic          c_in_range, d_in_range;
    logic          c_rvalid_q, d_rvalid_q;
    logic [31:0]   c_rdata_q, d_rdata_q;

    // Reset wins over every request, so no grant or write escapes during rst.
    assign arb_en  = (state_q == IDLE) && !rst;
    assign arb_req = arb_en ? {d_req, c_req} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .en  (arb_en),
        .gnt (arb_gnt)
    );

    assign c_gnt      = arb_gnt[ID_C];
    assign d_gnt      = arb_gnt[ID_D];
    assign c_in_range = c_addr < AW'(DEPTH);
    assign d_in_range = d_addr < AW'(DEPTH);
    assign clr_busy   = (state_q == CLEAR);

    always_comb begin
        m_we = 1'b0;
        m_ad = '0;
        m_wd = '0;
        if (!rst && state_q == CLEAR) begin
            m_we = 1'b1;
            m_ad = cnt_q;
        end else if (c_gnt) begin
            m_we = c_we && c_in_range;
            m_ad = c_addr;
            m_wd = c_wd;
        end else if (d_gnt) begin
            m_we = d_we && d_in_range;
            m_ad = d_addr;
            m_wd = d_wd;
        end
    end

    // Out-of-range loads still complete, returning zero instead of m_rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_gnt && !c_we;
            d_rvalid_q <= d_gnt && !d_we;
            if (c_gnt && !c_we) begin
                c_rdata_q <= c_in_range ? m_rd : '0;
            end
            if (d_gnt && !d_we) begin
                d_rdata_q <= d_in_range ? m_rd : '0;
            end
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef DM_ARB_CLEAR_EN
    state_e        state_d;
    logic [AW-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    logic unused_clr_start;

    assign state_q          = IDLE;
    assign cnt_q            = '0;
    assign unused_clr_start = clr_start;
`endif

endmodule
